aes_result_checker: RTL

- Downstream checker stage of the pure-hardware verification platform. It consumes ciphertext blocks produced by the AES-128 core and compares each one, in order, against golden ciphertext supplied by the vector source.
- Golden blocks arrive ahead of DUT results, so they are buffered in an internal FIFO.
- Produces the total and correct counters exported at platform top, plus done and error flags.

---
 rtl/aes_result_checker.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/aes_result_checker.sv
// aes_result_checker
//   Compares AES-128 core ciphertext, in order, against golden ciphertext
//   from the vector source. Golden blocks arrive ahead of results, so they
//   are held in a DEPTH-entry FIFO. A run starts on a rising edge of work
//   and completes after NUM_VECTORS compares.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   work            run enable; rising edge starts a new run
//   exp_valid/data  golden block in, accepted when exp_ready
//   exp_ready       golden FIFO can accept (only while running)
//   dut_valid/data  AES core result pulse and ciphertext
//   total, correct  blocks compared / matched this run (saturating)
//   done            run complete, sticky until next run start or reset
//   orphan_err      sticky: result arrived with no golden block buffered
//   mismatch_seen   sticky: at least one compare failed
//   first_err_idx   value of total at the first mismatch
module aes_result_checker #(
  parameter int DEPTH       = 8,
  parameter int CNT_W       = 16,
  parameter int NUM_VECTORS = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             work,
  input  logic             exp_valid,
  input  logic [127:0]     exp_data,
  output logic             exp_ready,
  input  logic             dut_valid,
  input  logic [127:0]     dut_data,
  output logic [CNT_W-1:0] total,
  output logic [CNT_W-1:0] correct,
  output logic             done,
  output logic             orphan_err,
  output logic             mismatch_seen,
  output logic [CNT_W-1:0] first_err_idx
);

  localparam int AW = $clog2(DEPTH);
  // NUM_VECTORS may exceed the counter range; compare in a wide domain so a
  // saturated counter never falsely matches a truncated target.
  localparam logic [CNT_W+31:0] NV_EXT = (CNT_W+32)'(NUM_VECTORS);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e           state_q, state_d;
  logic             work_q;
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [127:0]     mem_q [DEPTH];
  logic             cmp_vld_q, cmp_vld_d;
  logic             cmp_eq_q, cmp_eq_d;
  logic [CNT_W-1:0] total_q, total_d;
  logic [CNT_W-1:0] correct_q, correct_d;
  logic [CNT_W-1:0] first_err_idx_q, first_err_idx_d;
  logic             done_q, done_d;
  logic             orphan_err_q, orphan_err_d;
  logic             mismatch_seen_q, mismatch_seen_d;

  logic             full, empty, push, work_rise, fin;
  logic [127:0]     head;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign head      = mem_q[rd_ptr_q[AW-1:0]];
  assign exp_ready = (state_q == S_RUN) && !full;
  assign push      = exp_ready && exp_valid;
  assign work_rise = work && !work_q;

  always_comb begin
    state_d         = state_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    cmp_vld_d       = 1'b0;
    cmp_eq_d        = (dut_data == head);
    total_d         = total_q;
    correct_d       = correct_q;
    first_err_idx_d = first_err_idx_q;
    done_d          = done_q;
    orphan_err_d    = orphan_err_q;
    mismatch_seen_d = mismatch_seen_q;
    fin             = 1'b0;

    case (state_q)
      S_RUN: begin
        // Retire the compare registered on the previous cycle.
        if (cmp_vld_q) begin
          total_d = sat_inc(total_q);
          if (cmp_eq_q) begin
            correct_d = sat_inc(correct_q);
          end else if (!mismatch_seen_q) begin
            mismatch_seen_d = 1'b1;
            first_err_idx_d = total_q;
          end
          fin = ({32'd0, total_d} == NV_EXT);
        end
        // A result is not taken on the cycle the run finishes or when the
        // run is being abandoned, so no popped entry is ever lost.
        if (dut_valid && work && !fin) begin
          if (empty) begin
            orphan_err_d = 1'b1;
          end else begin
            cmp_vld_d = 1'b1;
            rd_ptr_d  = rd_ptr_q + (AW+1)'(1);
          end
        end
        if (push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        if (fin) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else if (!work) begin
          state_d = S_IDLE;
        end
      end
      S_IDLE, S_DONE: begin
        if (work_rise) begin
          state_d         = S_RUN;
          wr_ptr_d        = '0;
          rd_ptr_d        = '0;
          total_d         = '0;
          correct_d       = '0;
          first_err_idx_d = '0;
          done_d          = 1'b0;
          orphan_err_d    = 1'b0;
          mismatch_seen_d = 1'b0;
        end else if (state_q == S_DONE && !work) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      work_q          <= 1'b0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      cmp_vld_q       <= 1'b0;
      total_q         <= '0;
      correct_q       <= '0;
      first_err_idx_q <= '0;
      done_q          <= 1'b0;
      orphan_err_q    <= 1'b0;
      mismatch_seen_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      work_q          <= work;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      cmp_vld_q       <= cmp_vld_d;
      total_q         <= total_d;
      correct_q       <= correct_d;
      first_err_idx_q <= first_err_idx_d;
      done_q          <= done_d;
      orphan_err_q    <= orphan_err_d;
      mismatch_seen_q <= mismatch_seen_d;
    end
  end

  // Datapath storage: qualified by the control flops, so left unreset.
  always_ff @(posedge clk) begin
    cmp_eq_q <= cmp_eq_d;
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= exp_data;
  end

  assign total         = total_q;
  assign correct       = correct_q;
  assign done          = done_q;
  assign orphan_err    = orphan_err_q;
  assign mismatch_seen = mismatch_seen_q;
  assign first_err_idx = first_err_idx_q;

endmodule
